// File: rtl/ili_spi_tx_pkg.sv
// Shared types and constants for the ILI9341 SPI transmitter.
// Pin levels, FSM state encoding and default clock divider.
package ili_spi_tx_pkg;

    localparam logic HIGH = 1'b1;
    localparam logic LOW  = 1'b0;
    localparam logic ON   = 1'b1;
    localparam logic OFF  = 1'b0;

    localparam logic [7:0] NO_DATA = 8'h00;

    localparam int SPI_CLK_DIV = 4;

    typedef enum logic [1:0] {
        SPI_IDLE,
        SPI_SHIFT,
        SPI_DONE
    } spi_state_t;

endpackage

// File: rtl/ili_spi_tx_if.sv
// Upstream request/response bundle between the init/command
// controller (master) and the SPI transmitter (slave).
interface ili_spi_tx_if #(
    parameter int DW = 8
);
    logic          send;
    logic [DW-1:0] data;
    logic          dc;
    logic          cs;
    logic          reset;
    logic          sent;
    logic          busy;

    modport master (
        output send, data, dc, cs, reset,
        input  sent, busy
    );

    modport slave (
        input  send, data, dc, cs, reset,
        output sent, busy
    );
endinterface

// File: rtl/ili_spi_tx_clk_div.sv
// Half-period tick generator for SCK: a down-counter that
// reloads on start and ticks once every CLK_DIV enabled cycles.
module ili_spi_clk_div #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic start_i,
    input  logic en_i,
    output logic tick_o
);
    localparam int CW = $clog2(CLK_DIV + 1);
    localparam logic [CW-1:0] RELOAD = CW'(CLK_DIV - 1);

    logic [CW-1:0] div_cnt_q;

    assign tick_o = en_i && (div_cnt_q == '0);

    // Count down while enabled, reload on start and on every tick.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt_q <= '0;
        end else if (start_i) begin
            div_cnt_q <= RELOAD;
        end else if (en_i) begin
            if (div_cnt_q == '0) begin
                div_cnt_q <= RELOAD;
            end else begin
                div_cnt_q <= div_cnt_q - CW'(1);
            end
        end
    end
endmodule

// File: rtl/ili_spi_tx.sv
// SPI mode-0, MSB-first word transmitter driving the ILI9341 pins.
// One word per send request; sent pulses once per completed word.
module ili_spi_tx
    import ili_spi_tx_pkg::*;
#(
    parameter int DW      = 8,
    parameter int CLK_DIV = SPI_CLK_DIV
) (
    input  logic         clk,
    input  logic         rst,
    ili_spi_tx_if.slave  bus,
    output logic         lcd_sck,
    output logic         lcd_mosi,
    output logic         lcd_dc,
    output logic         lcd_cs,
    output logic         lcd_rst
);
    localparam int HW = $clog2(2 * DW + 1);
    localparam logic [HW-1:0] LAST_HALF = HW'(2 * DW - 1);

    spi_state_t    state_q;
    logic [DW-1:0] shreg_q;
    logic [DW-1:0] shreg_d;
    logic [HW-1:0] half_cnt_q;
    logic          armed_q;
    logic          sck_q;
    logic          mosi_q;
    logic          dc_q;
    logic          cs_q;
    logic          rst_q;
    logic          sent_q;
    logic          busy_q;
    logic          start;
    logic          tick;

    assign start   = (state_q == SPI_IDLE) && bus.send && armed_q;
    assign shreg_d = shreg_q << 1;

    ili_spi_clk_div #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_div (
        .clk     (clk),
        .rst     (rst),
        .start_i (start),
        .en_i    (state_q == SPI_SHIFT),
        .tick_o  (tick)
    );

    // Transaction FSM, shifter and registered panel-side outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= SPI_IDLE;
            shreg_q    <= NO_DATA[DW-1:0];
            half_cnt_q <= '0;
            armed_q    <= HIGH;
            sck_q      <= LOW;
            mosi_q     <= LOW;
            dc_q       <= HIGH;
            cs_q       <= HIGH;
            sent_q     <= LOW;
            busy_q     <= LOW;
        end else begin
            sent_q <= LOW;
            if (!bus.send) begin
                armed_q <= HIGH;
            end
            unique case (state_q)
                SPI_IDLE: begin
                    if (start) begin
                        shreg_q    <= bus.data;
                        dc_q       <= bus.dc;
                        armed_q    <= LOW;
                        mosi_q     <= bus.data[DW-1];
                        sck_q      <= LOW;
                        half_cnt_q <= '0;
                        busy_q     <= HIGH;
                        cs_q       <= LOW;
                        state_q    <= SPI_SHIFT;
                    end else begin
                        cs_q <= bus.cs;
                    end
                end
                SPI_SHIFT: begin
                    cs_q <= LOW;
                    if (tick) begin
                        sck_q      <= ~sck_q;
                        half_cnt_q <= half_cnt_q + HW'(1);
                        if (sck_q) begin
                            // Falling edge: advance to the next bit,
                            // except after the last bit, which stays.
                            if (half_cnt_q == LAST_HALF) begin
                                sent_q  <= HIGH;
                                state_q <= SPI_DONE;
                            end else begin
                                shreg_q <= shreg_d;
                                mosi_q  <= shreg_d[DW-1];
                            end
                        end
                    end
                end
                SPI_DONE: begin
                    sck_q   <= LOW;
                    busy_q  <= LOW;
                    cs_q    <= bus.cs;
                    state_q <= SPI_IDLE;
                end
                default: begin
                    state_q <= SPI_IDLE;
                end
            endcase
        end
    end

    // Panel reset follows the upstream request one cycle later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rst_q <= HIGH;
        end else begin
            rst_q <= bus.reset;
        end
    end

    assign lcd_sck  = sck_q;
    assign lcd_mosi = mosi_q;
    assign lcd_dc   = dc_q;
    assign lcd_cs   = cs_q;
    assign lcd_rst  = rst_q;
    assign bus.sent = sent_q;
    assign bus.busy = busy_q;
endmodule
